// File: rtl/mips_cpu_instruction_queue.sv
// Instruction prefetch queue between instruction memory and decode: circular buffer of {pc, instr}.
// Optional 0-cycle bypass of an empty queue when MIPS_CPU_IQ_BYPASS_EN is defined.
module mips_cpu_instruction_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [5:0]       control_input,
  output logic [4:0]       source_1,
  output logic [4:0]       source_2,
  output logic [4:0]       dest,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      immediate,
  output logic [25:0]      jmp_address,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = PC_W + 32;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             bypass_take;
  logic [ENT_W-1:0] head;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = !full;

  // Head selection; an empty queue may forward the incoming word straight through
  always_comb begin
    out_valid   = !empty;
    head        = mem[rd_ptr];
    bypass_take = 1'b0;
`ifdef MIPS_CPU_IQ_BYPASS_EN
    if (empty && !flush) begin
      out_valid   = in_valid;
      head        = {in_pc, in_instr};
      bypass_take = in_valid && out_ready;
    end
`endif
  end

  // A bypassed word consumed in the same cycle never enters storage
  assign push = in_valid && in_ready && !flush && !bypass_take;
  assign pop  = out_valid && out_ready && !empty && !flush;

  // Invalid head is presented as all-zero (opcode 0 / funct 0 decodes as nop)
  assign {out_pc, out_instr} = out_valid ? head : '0;

  assign control_input = out_instr[31:26];
  assign source_1      = out_instr[25:21];
  assign source_2      = out_instr[20:16];
  assign dest          = out_instr[15:11];
  assign shamt         = out_instr[10:6];
  assign funct         = out_instr[5:0];
  assign immediate     = out_instr[15:0];
  assign jmp_address   = out_instr[25:0];

  // Storage carries no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_pc, in_instr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_mips_cpu_instruction_queue.sv
// Self-checking bench for mips_cpu_instruction_queue: vector table, directed corner cases and a
// random run against a queue-based reference model. Follows MIPS_CPU_IQ_BYPASS_EN if defined.
module tb_mips_cpu_instruction_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
`ifdef MIPS_CPU_IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_instr, out_instr;
  logic [PC_W-1:0]  in_pc, out_pc;
  logic [5:0]       control_input, funct;
  logic [4:0]       source_1, source_2, dest, shamt;
  logic [15:0]      immediate;
  logic [25:0]      jmp_address;
  logic [CNT_W-1:0] count;

  mips_cpu_instruction_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .control_input(control_input), .source_1(source_1), .source_2(source_2), .dest(dest),
    .shamt(shamt), .funct(funct), .immediate(immediate), .jmp_address(jmp_address),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [PC_W+31:0] q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_valid(input logic f, input logic v);
    return (q.size() != 0) || (BYP && v && !f);
  endfunction

  function automatic logic [PC_W+31:0] exp_head(input logic f, input logic v);
    if (q.size() != 0) return q[0];
    if (BYP && v && !f) return {in_pc, in_instr};
    return '0;
  endfunction

  // Model outputs for the inputs currently applied
  task automatic check_outputs(input string tag, input logic f, input logic v);
    logic [PC_W+31:0] e;
    logic [31:0]      ei;
    e  = exp_head(f, v);
    ei = e[31:0];
    chk({tag, " count"}, 128'(count), 128'(q.size()));
    chk({tag, " in_ready"}, 128'(in_ready), 128'(q.size() < DEPTH));
    chk({tag, " out_valid"}, 128'(out_valid), 128'(exp_valid(f, v)));
    chk({tag, " head"}, 128'({out_pc, out_instr}), 128'(e));
    chk({tag, " fields"},
        128'({control_input, source_1, source_2, dest, shamt, funct, immediate, jmp_address}),
        128'({ei[31:26], ei[25:21], ei[20:16], ei[15:11], ei[10:6], ei[5:0], ei[15:0], ei[25:0]}));
  endtask

  // Reference behaviour at a clock edge
  task automatic model_edge(input logic f, input logic v, input logic r,
                            input logic [31:0] instr, input logic [PC_W-1:0] pc);
    int   sz;
    logic consumed, accepted;
    sz = q.size();
    if (f) begin
      q.delete();
    end else begin
      consumed = exp_valid(f, v) && r;
      accepted = v && (sz < DEPTH);
      if (consumed && sz != 0) void'(q.pop_front());
      if (accepted && !(consumed && sz == 0)) q.push_back({pc, instr});
    end
  endtask

  task automatic step(input string tag, input logic f, input logic v, input logic r,
                      input logic [31:0] instr, input logic [PC_W-1:0] pc);
    flush = f; in_valid = v; out_ready = r; in_instr = instr; in_pc = pc;
    #1 check_outputs(tag, f, v);
    @(posedge clk);
    model_edge(f, v, r, instr, pc);
    #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  typedef struct {
    logic        fl, v, r;
    logic [31:0] instr;
    logic [3:0]  cnt;
    logic        ov, ir;
    logic [31:0] head;
  } vec_t;
  vec_t tbl[12];

  initial begin
    logic f, v, r;
    logic [31:0] w;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;

    // Fill, refuse-while-full, wrap and drain; state checked after each edge with idle inputs
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h11, 4'd1, 1'b1, 1'b1, 32'h11};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h22, 4'd2, 1'b1, 1'b1, 32'h11};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h33, 4'd3, 1'b1, 1'b1, 32'h11};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h44, 4'd4, 1'b1, 1'b0, 32'h11};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h00, 4'd3, 1'b1, 1'b1, 32'h22};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h00, 4'd2, 1'b1, 1'b1, 32'h33};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h55, 4'd3, 1'b1, 1'b1, 32'h33};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h66, 4'd4, 1'b1, 1'b0, 32'h33};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h77, 4'd3, 1'b1, 1'b1, 32'h44};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h00, 4'd2, 1'b1, 1'b1, 32'h55};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h00, 4'd1, 1'b1, 1'b1, 32'h66};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h00, 4'd0, 1'b0, 1'b1, 32'h00};

    #12;
    chk("reset count", 128'(count), 128'(0));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset in_ready", 128'(in_ready), 128'(1));
    chk("reset out_instr", 128'(out_instr), 128'(0));
    chk("reset control_input", 128'(control_input), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single push and decode of lw $3,4($2)
    step("lw", 1'b0, 1'b1, 1'b0, 32'h8C430004, 32'h00400000);
    #1;
    chk("lw out_valid", 128'(out_valid), 128'(1));
    chk("lw control_input", 128'(control_input), 128'(6'h23));
    chk("lw source_1", 128'(source_1), 128'(2));
    chk("lw source_2", 128'(source_2), 128'(3));
    chk("lw immediate", 128'(immediate), 128'(16'h0004));
    chk("lw out_pc", 128'(out_pc), 128'(32'h00400000));
    step("lw pop", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    for (int i = 0; i < 12; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].fl, tbl[i].v, tbl[i].r, tbl[i].instr,
           {tbl[i].instr[29:0], 2'b00});
      #1;
      chk($sformatf("tbl%0d count", i), 128'(count), 128'(tbl[i].cnt));
      chk($sformatf("tbl%0d out_valid", i), 128'(out_valid), 128'(tbl[i].ov));
      chk($sformatf("tbl%0d in_ready", i), 128'(in_ready), 128'(tbl[i].ir));
      chk($sformatf("tbl%0d head", i), 128'(out_instr), 128'(tbl[i].head));
    end

    // Sustained push+pop at occupancy 2
    step("pp fill0", 1'b0, 1'b1, 1'b0, 32'hA0, 32'h100);
    step("pp fill1", 1'b0, 1'b1, 1'b0, 32'hA1, 32'h104);
    for (int i = 0; i < 10; i++) begin
      step($sformatf("pp%0d", i), 1'b0, 1'b1, 1'b1, 32'hB0 + 32'(i), 32'h200 + 32'(4 * i));
      #1 chk($sformatf("pp%0d count", i), 128'(count), 128'(2));
    end

    // Flush with a simultaneous push offered
    step("fl push", 1'b0, 1'b1, 1'b0, 32'hC0, 32'h300);
    step("fl flush", 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h304);
    #1;
    chk("flush count", 128'(count), 128'(0));
    chk("flush out_valid", 128'(out_valid), 128'(0));
    step("fl after0", 1'b0, 1'b1, 1'b0, 32'hC1, 32'h308);
    step("fl after1", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step("fl after2", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Jump word offered to an empty queue with out_ready high
    flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h08100000; in_pc = 32'h400;
    #1;
`ifdef MIPS_CPU_IQ_BYPASS_EN
    chk("bypass same-cycle valid", 128'(out_valid), 128'(1));
    chk("bypass jmp_address", 128'(jmp_address), 128'(26'h0100000));
`else
    chk("reg same-cycle valid", 128'(out_valid), 128'(0));
`endif
    @(posedge clk);
    model_edge(1'b0, 1'b1, 1'b1, 32'h08100000, 32'h400);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    #1;
`ifdef MIPS_CPU_IQ_BYPASS_EN
    chk("bypass next count", 128'(count), 128'(0));
`else
    chk("reg next valid", 128'(out_valid), 128'(1));
    chk("reg next jmp_address", 128'(jmp_address), 128'(26'h0100000));
`endif
    step("byp drain", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Asynchronous reset mid-stream
    step("rst push0", 1'b0, 1'b1, 1'b0, 32'hE0, 32'h500);
    step("rst push1", 1'b0, 1'b1, 1'b0, 32'hE1, 32'h504);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst count", 128'(count), 128'(0));
    chk("midrst out_valid", 128'(out_valid), 128'(0));
    chk("midrst in_ready", 128'(in_ready), 128'(1));
    chk("midrst out_instr", 128'(out_instr), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 400; i++) begin
      f = 1'($urandom_range(15) == 0);
      v = 1'($urandom_range(3) != 0);
      r = 1'($urandom_range(2) != 0);
      w = $urandom;
      step("rand", f, v, r, w, 32'($urandom));
    end
    for (int i = 0; i < DEPTH + 2; i++) step("drain", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    #1 chk("final count", 128'(count), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_cpu_instruction_queue.md
# mips_cpu_instruction_queue

Parametrised instruction prefetch queue between instruction memory and the control/decode stage. It buffers up to DEPTH fetched words with their PCs behind valid/ready handshakes. It supports a single-cycle flush for taken branches and jumps. The MIPS fields of the head entry are presented directly to the control unit and register file.

## Interface
- DEPTH, 4: number of entries; power of two, ≥ 2.
- PC_W, 32: width of the stored PC tag.
- CNT_W, $clog2(DEPTH+1): width of `count` (derived, not overridden).

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries (synchronous)
- in_valid  in  1  fetch word offered
- in_ready  out  1  queue can accept a word
- in_instr  in  32  fetched instruction
- in_pc  in  PC_W  address of in_instr
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head
- out_instr  out  32  head instruction
- out_pc  out  PC_W  head PC
- control_input  out  6  out_instr[31:26]
- source_1  out  5  out_instr[25:21]
- source_2  out  5  out_instr[20:16]
- dest  out  5  out_instr[15:11]
- shamt  out  5  out_instr[10:6]
- funct  out  6  out_instr[5:0]
- immediate  out  16  out_instr[15:0]
- jmp_address  out  26  out_instr[25:0]
- count  out  CNT_W  occupied entries, 0..DEPTH

The design has one clock. Reset is asynchronous and active-low.

## Operation
- Storage is a circular buffer with wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap) and count.
- Push occurs when in_valid && in_ready: the entry is written at wr_ptr, and wr_ptr increments.
- Pop occurs when out_valid && out_ready: rd_ptr increments.
- in_ready = (count != DEPTH). A full queue refuses a push even if a pop occurs in the same cycle.
- out_valid = (count != 0) in registered mode.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- flush = 1: at the next edge, count, wr_ptr and rd_ptr all become 0. Flush has priority over any push or pop in that cycle, and a push offered in a flush cycle is dropped.
- When out_valid = 0, out_instr, out_pc and all decoded fields are driven to 0, so the control unit sees opcode 0 / funct 0 (sll $0 = nop).
- Decoded fields are pure slices of out_instr, with no extra register.

## Timing
- Reset (rst_n low, asynchronous):
  - count = 0, pointers = 0
  - out_valid = 0, in_ready = 1
  - out_instr, out_pc and all fields = 0
  - Storage contents are don't-care.
- Registered-mode latency: a word pushed at edge N is visible on out_* after edge N with out_valid = 1 (1 cycle).
- Throughput: one push and one pop per cycle sustained at any occupancy from 1 to DEPTH−1.
- Full (count = DEPTH): in_ready = 0. It returns to 1 the cycle after a pop.
- Empty (count = 0): out_valid = 0. out_ready is ignored.
- Order: strict FIFO across pointer wrap-around.
- Reset asserted mid-stream: the queue empties immediately, with no partial state retained.

## Configuration
- MIPS_CPU_IQ_BYPASS_EN defined (bypass mode):
  - When count = 0 and flush = 0, out_valid = in_valid. out_instr, out_pc and the fields follow in_instr/in_pc combinationally, giving 0-cycle latency.
  - If out_ready = 1 in that cycle, the word is consumed without being written: count stays 0 and the pointers do not move.
  - If out_ready = 0, the word is pushed normally.
  - When count ≠ 0, behaviour is identical to registered mode.
- MIPS_CPU_IQ_BYPASS_EN undefined: registered mode only. There is no combinational path from in_* to out_*.

## Test plan
- Reset and empty behaviour: rst_n low then high, in_valid = 0.
  - Required: count = 0, out_valid = 0, in_ready = 1, out_instr = 0, control_input = 0.
- Single push and field decode: push 0x8C430004 at PC 0x00400000 (lw $3,4($2)).
  - Required next cycle: out_valid = 1, control_input = 0x23, source_1 = 2, source_2 = 3, immediate = 0x0004, out_pc = 0x00400000.
- Fill and wrap (DEPTH = 4): push 0x11, 0x22, 0x33, 0x44 with out_ready = 0.
  - Required after filling: count = 4, in_ready = 0.
  - Then pop 2 and push 0x55, 0x66. Required pop order: 0x11, 0x22, 0x33, 0x44, 0x55, 0x66, with no loss across the wrap.
- Simultaneous push/pop at count = 2 for 10 cycles.
  - Required: count stays 2, and the output sequence is in input order.
- Flush with push: count = 3, flush = 1 and in_valid = 1 in the same cycle.
  - Required next cycle: count = 0, out_valid = 0, and the offered word is absent from all later pops.
- Bypass (MIPS_CPU_IQ_BYPASS_EN defined): queue empty, in_valid = 1, in_instr = 0x08100000, out_ready = 1.
  - Required same cycle: out_valid = 1, jmp_address = 0x0100000.
  - Required next cycle: count = 0.
  - Without the macro, the same stimulus gives out_valid = 0 in that cycle and 1 the following cycle.
